vga_scanout: RTL

Pixel-clock-domain scan-out stage of the VGA output path. It generates horizontal and vertical timing from programmable mode registers and pulls RGB565 pixels from the framebuffer pixel FIFO read port during the active area. It expands the pixels to 8-bit-per-channel and drives the registered VGA pad signals. It sits between the framebuffer fetch/FIFO logic in `vgafb` and the VGA pads, clocked by the selected, BUFG-driven pixel clock.

---
 rtl/vga_scanout_pkg.sv | 29 ++
 rtl/vga_scanout_if.sv | 9 +
 rtl/vga_scan_counter.sv | 41 ++++
 rtl/vga_scanout.sv | 95 +++++++++
 4 files changed

// File: rtl/vga_scanout_pkg.sv
// Shared types for the VGA scan-out stage: timing width, per-axis mode
// registers and the RGB565 -> RGB888 expansion.
package vga_scanout_pkg;

  localparam int unsigned TW = 11;

  typedef struct packed {
    logic [TW-1:0] res;
    logic [TW-1:0] sync_start;
    logic [TW-1:0] sync_end;
    logic [TW-1:0] scan;
  } mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicate the MSBs into the new LSBs so full-scale stays full-scale.
  function automatic rgb888_t expand565(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel FIFO read port between the framebuffer FIFO (master) and scan-out (slave).
interface vga_scanout_if;
  logic [15:0] pix_dat;
  logic        pix_valid;
  logic        pix_ack;

  modport master (output pix_dat, output pix_valid, input pix_ack);
  modport slave  (input pix_dat, input pix_valid, output pix_ack);
endinterface

// File: rtl/vga_scan_counter.sv
// One timing axis: position counter with wrap, plus active and sync decode
// against the shadowed mode registers.
module vga_scan_counter
  import vga_scanout_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  mode_t         mode,
  output logic [TW-1:0] cnt,
  output logic          wrap,
  output logic          act,
  output logic          sync
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = inc && (cnt_q == mode.scan);
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + TW'(1);
    end
    act  = cnt_q < mode.res;
    sync = (cnt_q >= mode.sync_start) && (cnt_q < mode.sync_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_scanout.sv
// Pixel-clock scan-out: h/v timing from shadowed mode registers, FIFO pop
// during the active area, and registered RGB888/sync/power-save pad outputs.
module vga_scanout #(
  parameter int unsigned TW = vga_scanout_pkg::TW
) (
  input  logic          vga_clk,
  input  logic          vga_rst_n,
  input  logic          enable,
  input  logic [TW-1:0] hres,
  input  logic [TW-1:0] hsync_start,
  input  logic [TW-1:0] hsync_end,
  input  logic [TW-1:0] hscan,
  input  logic [TW-1:0] vres,
  input  logic [TW-1:0] vsync_start,
  input  logic [TW-1:0] vsync_end,
  input  logic [TW-1:0] vscan,
  vga_scanout_if.slave  pix,
  output logic          frame_start,
  output logic          underrun,
  input  logic          underrun_clr,
  output logic          vga_hsync_n,
  output logic          vga_vsync_n,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_psave_n
);
  import vga_scanout_pkg::*;

  mode_t         h_mode_q, h_mode_d, v_mode_q, v_mode_d;
  rgb888_t       rgb_q, rgb_d;
  logic          hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic          psave_n_q, psave_n_d, underrun_q, underrun_d;
  logic [TW-1:0] hcnt, vcnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic          active, load;

  vga_scan_counter u_hcnt (
    .clk(vga_clk), .rst_n(vga_rst_n), .clr(!enable), .inc(enable),
    .mode(h_mode_q), .cnt(hcnt), .wrap(h_wrap), .act(h_act), .sync(h_sync)
  );

  vga_scan_counter u_vcnt (
    .clk(vga_clk), .rst_n(vga_rst_n), .clr(!enable), .inc(h_wrap),
    .mode(v_mode_q), .cnt(vcnt), .wrap(v_wrap), .act(v_act), .sync(v_sync)
  );

  always_comb begin
    active      = enable && h_act && v_act;
    pix.pix_ack = active && pix.pix_valid;
    // Qualified by reset so the pulse stays low while the block is held in reset.
    frame_start = vga_rst_n && enable && (hcnt == '0) && (vcnt == '0);

    load     = !enable || (h_wrap && v_wrap);
    h_mode_d = load ? '{res: hres, sync_start: hsync_start, sync_end: hsync_end, scan: hscan}
                    : h_mode_q;
    v_mode_d = load ? '{res: vres, sync_start: vsync_start, sync_end: vsync_end, scan: vscan}
                    : v_mode_q;

    rgb_d      = pix.pix_ack ? expand565(pix.pix_dat) : '0;
    hsync_n_d  = !(enable && h_sync);
    vsync_n_d  = !(enable && v_sync);
    psave_n_d  = enable;
    underrun_d = (active && !pix.pix_valid) || (underrun_q && !underrun_clr);
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      h_mode_q   <= '0;
      v_mode_q   <= '0;
      rgb_q      <= '0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
      psave_n_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      h_mode_q   <= h_mode_d;
      v_mode_q   <= v_mode_d;
      rgb_q      <= rgb_d;
      hsync_n_q  <= hsync_n_d;
      vsync_n_q  <= vsync_n_d;
      psave_n_q  <= psave_n_d;
      underrun_q <= underrun_d;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hsync_n = hsync_n_q;
  assign vga_vsync_n = vsync_n_q;
  assign vga_psave_n = psave_n_q;
  assign underrun    = underrun_q;

endmodule
